// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
// Walks the 12-bit serial ADC engine through the channels enabled in a latched
// mask and keeps the newest result of every channel in a small register file.
// The engine is pipelined by one transaction: the configuration word sent now
// selects the channel whose result arrives with the *next* conv_done. A scan
// therefore begins with a priming transaction, and it ends with a wrap-around
// transaction that re-configures the first channel.
//
// Ports
//   clk, reset         system clock, asynchronous active-low reset
//   i_enable           continuous-mode run enable (level)
//   i_start            single-shot scan request (pulse, honoured only when idle)
//   i_ch_mask          enabled channels, latched at scan start
//   i_period           scan interval in clk cycles, 0 = back-to-back
//   i_flag_clr         clears the overrun / timeout flags
//   o_conv_req         transaction request to the ADC engine
//   o_conv_conf        engine config word {S/D, O/S, S1, S0, UNI, SLP}
//   i_conv_ack         engine accepted the request (pulse)
//   i_conv_done        i_conv_data valid (pulse)
//   i_conv_data        result of the previously configured conversion
//   i_rd_ch/o_rd_data  combinational register-file read port
//   o_sample_*         one-cycle notification of every stored result
//   o_scan_done        end-of-scan pulse
//   o_busy             scan in progress
//   o_overrun          sticky: period tick arrived while busy
//   o_timeout_err      sticky: conv_done missing within TIMEOUT cycles
module adc_scan_sequencer #(
   parameter int NUM_CH  = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_enable,
   input  logic              i_start,
   input  logic [NUM_CH-1:0] i_ch_mask,
   input  logic [15:0]       i_period,
   input  logic              i_flag_clr,
   output logic              o_conv_req,
   output logic [5:0]        o_conv_conf,
   input  logic              i_conv_ack,
   input  logic              i_conv_done,
   input  logic [11:0]       i_conv_data,
   input  logic [2:0]        i_rd_ch,
   output logic [11:0]       o_rd_data,
   output logic              o_sample_valid,
   output logic [2:0]        o_sample_ch,
   output logic [11:0]       o_sample_data,
   output logic              o_scan_done,
   output logic              o_busy,
   output logic              o_overrun,
   output logic              o_timeout_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQ       = 3'd1,
      S_WAIT_ACK  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_STORE     = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [5:0]        w_conf_nxt;
   logic [NUM_CH-1:0] r_mask;
   logic [2:0]        r_ptr;
   logic [2:0]        r_prev_ch;
   logic              r_prev_vld;
   logic [15:0]       r_per_cnt;
   logic [TW-1:0]     r_to_cnt;
   logic [11:0]       r_results [0:NUM_CH-1];
   logic              r_conv_req;
   logic [5:0]        r_conv_conf;
   logic              r_sample_valid;
   logic [2:0]        r_sample_ch;
   logic [11:0]       r_sample_data;
   logic              r_scan_done;
   logic              r_busy;
   logic              r_overrun;
   logic              r_timeout_err;
   logic              w_tick;
   logic              w_launch;
   logic              w_store;
   logic              w_last;
   logic              w_abort;

   // Lowest enabled channel of a mask (first channel of a scan).
   function automatic logic [2:0] f_lowest(input logic [NUM_CH-1:0] m);
      logic [2:0] r;
      r = 3'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Next enabled channel above cur, wrapping to the lowest one.
   function automatic logic [2:0] f_next(input logic [NUM_CH-1:0] m, input logic [2:0] cur);
      logic [2:0] r;
      r = f_lowest(m);
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) r = 3'(i);
      end
      return r;
   endfunction

   // True when no enabled channel lies above cur.
   function automatic logic f_is_last(input logic [NUM_CH-1:0] m, input logic [2:0] cur);
      logic r;
      r = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (m[i] && (i > int'(cur))) r = 1'b0;
      end
      return r;
   endfunction

   // Single-ended, unipolar, awake: {S/D, O/S, S1, S0, UNI, SLP}.
   function automatic logic [5:0] f_cfg(input logic [2:0] ch);
      return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
   endfunction

   // With period 0 ticks are only meaningful in IDLE, so back-to-back mode never overruns.
   assign w_tick   = i_enable && ((i_period == 16'd0) ? (r_state == S_IDLE)
                                                      : (r_per_cnt == (i_period - 16'd1)));
   assign w_launch = (r_state == S_IDLE) && (i_start || w_tick) && (i_ch_mask != '0);
   // Priming data (prev channel not yet valid) is never stored.
   assign w_store  = (r_state == S_WAIT_DONE) && i_conv_done && r_prev_vld;
   assign w_last   = w_store && f_is_last(r_mask, r_prev_ch);
   assign w_abort  = (r_state == S_WAIT_DONE) && !i_conv_done && (r_to_cnt == TW'(TIMEOUT - 1));

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode and the config word to present on entering REQ.
   always_comb begin
      w_state_nxt = r_state;
      w_conf_nxt  = r_conv_conf;
      case (r_state)
         S_IDLE: begin
            if (w_launch) begin
               w_state_nxt = S_REQ;
               w_conf_nxt  = f_cfg(f_lowest(i_ch_mask));
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_REQ, S_WAIT_ACK: begin
            if (i_conv_ack) w_state_nxt = S_WAIT_DONE;
            else            w_state_nxt = S_WAIT_ACK;
         end
         S_WAIT_DONE: begin
            if (i_conv_done) begin
               if (w_last) w_state_nxt = S_IDLE;
               else        w_state_nxt = S_STORE;
            end else if (w_abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_WAIT_DONE;
            end
         end
         S_STORE: begin
            w_state_nxt = S_REQ;
            w_conf_nxt  = f_cfg(r_ptr);
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Scan bookkeeping: latched mask, channel pointer, pipeline channel, result file.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mask     <= '0;
         r_ptr      <= 3'd0;
         r_prev_ch  <= 3'd0;
         r_prev_vld <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) r_results[k] <= 12'd0;
      end else if (w_launch) begin
         r_mask     <= i_ch_mask;
         r_ptr      <= f_lowest(i_ch_mask);
         r_prev_vld <= 1'b0;
      end else if ((r_state == S_WAIT_DONE) && i_conv_done) begin
         if (w_store) r_results[r_prev_ch] <= i_conv_data;
         r_prev_ch  <= r_ptr;
         r_prev_vld <= 1'b1;
         r_ptr      <= f_next(r_mask, r_ptr);
      end
   end

   // Period counter (cleared while disabled) and conv_done watchdog started by conv_ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_per_cnt <= 16'd0;
         r_to_cnt  <= '0;
      end else begin
         if (!i_enable || (i_period == 16'd0) || w_tick) r_per_cnt <= 16'd0;
         else                                          r_per_cnt <= r_per_cnt + 16'd1;
         // Loaded with 1 so the count equals cycles elapsed since the ack cycle.
         if (((r_state == S_REQ) || (r_state == S_WAIT_ACK)) && i_conv_ack) r_to_cnt <= TW'(1);
         else if (r_state == S_WAIT_DONE)                                 r_to_cnt <= r_to_cnt + TW'(1);
         else                                                              r_to_cnt <= r_to_cnt;
      end
   end

   // Registered handshake, sample and status outputs; flag set beats flag_clr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_conv_req     <= 1'b0;
         r_conv_conf    <= 6'd0;
         r_sample_valid <= 1'b0;
         r_sample_ch    <= 3'd0;
         r_sample_data  <= 12'd0;
         r_scan_done    <= 1'b0;
         r_busy         <= 1'b0;
         r_overrun      <= 1'b0;
         r_timeout_err  <= 1'b0;
      end else begin
         r_conv_req     <= (w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT_ACK);
         r_conv_conf    <= w_conf_nxt;
         r_sample_valid <= w_store;
         if (w_store) begin
            r_sample_ch   <= r_prev_ch;
            r_sample_data <= i_conv_data;
         end
         r_scan_done <= w_last;
         r_busy      <= (w_state_nxt != S_IDLE);
         if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
         else if (i_flag_clr)               r_overrun <= 1'b0;
         if (w_abort)         r_timeout_err <= 1'b1;
         else if (i_flag_clr) r_timeout_err <= 1'b0;
      end
   end

   assign o_conv_req     = r_conv_req;
   assign o_conv_conf    = r_conv_conf;
   assign o_rd_data      = r_results[i_rd_ch];
   assign o_sample_valid = r_sample_valid;
   assign o_sample_ch    = r_sample_ch;
   assign o_sample_data  = r_sample_data;
   assign o_scan_done    = r_scan_done;
   assign o_busy         = r_busy;
   assign o_overrun      = r_overrun;
   assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Testbench for adc_scan_sequencer: an ADC engine responder with random data,
// an output monitor, and a reference model that derives expected configs,
// samples and register contents from the channel list of each scan.
module tb_adc_scan_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_enable = 1'b0, i_start = 1'b0, i_flag_clr = 1'b0;
   logic [7:0]  i_ch_mask = 8'd0;
   logic [15:0] i_period = 16'd0;
   logic        i_conv_ack = 1'b0, i_conv_done = 1'b0;
   logic [11:0] i_conv_data = 12'd0;
   logic [2:0]  i_rd_ch = 3'd0;
   logic        o_conv_req, o_sample_valid, o_scan_done, o_busy, o_overrun, o_timeout_err;
   logic [5:0]  o_conv_conf;
   logic [11:0] o_rd_data, o_sample_data;
   logic [2:0]  o_sample_ch;

   adc_scan_sequencer #(.NUM_CH(8), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .i_enable(i_enable), .i_start(i_start),
      .i_ch_mask(i_ch_mask), .i_period(i_period), .i_flag_clr(i_flag_clr),
      .o_conv_req(o_conv_req), .o_conv_conf(o_conv_conf), .i_conv_ack(i_conv_ack),
      .i_conv_done(i_conv_done), .i_conv_data(i_conv_data), .i_rd_ch(i_rd_ch),
      .o_rd_data(o_rd_data), .o_sample_valid(o_sample_valid), .o_sample_ch(o_sample_ch),
      .o_sample_data(o_sample_data), .o_scan_done(o_scan_done), .o_busy(o_busy),
      .o_overrun(o_overrun), .o_timeout_err(o_timeout_err)
   );

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   int          cyc = 0;
   int          eng_lat = 4;
   bit          eng_no_done = 1'b0;
   bit          eng_busy = 1'b0;
   logic [5:0]  conf_q[$];
   logic [11:0] data_q[$];
   logic [11:0] fixed_q[$];
   logic [14:0] samp_q[$];
   int          start_times[$];
   int          done_cnt = 0;
   logic        busy_d = 1'b0;
   logic [11:0] model_res [0:7];

   always @(posedge clk) cyc <= cyc + 1;

   // ADC engine: ack immediately, answer eng_lat cycles after the ack.
   always begin
      @(posedge clk); #1;
      if (o_conv_req === 1'b1) begin
         logic [11:0] d;
         eng_busy = 1'b1;
         conf_q.push_back(o_conv_conf);
         i_conv_ack = 1'b1;
         @(posedge clk); #1;
         i_conv_ack = 1'b0;
         if (!eng_no_done) begin
            if (eng_lat > 1) begin
               repeat (eng_lat - 1) @(posedge clk);
               #1;
            end
            if (fixed_q.size() > 0) d = fixed_q.pop_front();
            else                    d = 12'($urandom_range(0, 4095));
            data_q.push_back(d);
            i_conv_data = d;
            i_conv_done = 1'b1;
            @(posedge clk); #1;
            i_conv_done = 1'b0;
         end
         eng_busy = 1'b0;
      end
   end

   // Output monitor.
   always begin
      @(posedge clk); #1;
      if (o_sample_valid === 1'b1) samp_q.push_back({o_sample_ch, o_sample_data});
      if (o_scan_done === 1'b1) done_cnt++;
      if (o_busy === 1'b1 && busy_d === 1'b0) start_times.push_back(cyc);
      busy_d = o_busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #2;
   endtask

   function automatic logic [5:0] cfg_of(input int ch);
      return 6'(32'h22 | ((ch & 1) << 4) | (((ch >> 2) & 1) << 3) | (((ch >> 1) & 1) << 2));
   endfunction

   task automatic chk_rd_all(input string tag);
      for (int c = 0; c < 8; c++) begin
         i_rd_ch = 3'(c);
         #1;
         chk({tag, "_rd"}, 32'(o_rd_data), 32'(model_res[c]));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_outs"}, 32'({o_conv_req, o_conv_conf, o_sample_valid, o_sample_ch, o_sample_data,
                               o_scan_done, o_busy, o_overrun, o_timeout_err}), 32'd0);
      chk_rd_all(tag);
   endtask

   task automatic clear_logs();
      conf_q.delete(); data_q.delete(); samp_q.delete(); start_times.delete();
      done_cnt = 0;
   endtask

   // One single-shot scan, checked against the channel list of the mask.
   task automatic run_scan(input logic [7:0] m, input string tag);
      int chs[$];
      int n;
      clear_logs();
      for (int c = 0; c < 8; c++) if (m[c]) chs.push_back(c);
      n = chs.size();
      i_ch_mask = m; i_start = 1'b1; step(); i_start = 1'b0;
      for (int k = 0; k < 3000 && done_cnt == 0; k++) step();
      step();
      chk({tag, "_done"}, 32'(done_cnt), 32'd1);
      chk({tag, "_nreq"}, 32'(conf_q.size()), 32'(n + 1));
      for (int k = 0; k <= n && k < conf_q.size(); k++)
         chk({tag, "_conf"}, 32'(conf_q[k]), 32'(cfg_of(chs[k % n])));
      chk({tag, "_nsamp"}, 32'(samp_q.size()), 32'(n));
      for (int k = 0; k < n && k + 1 < data_q.size(); k++) begin
         model_res[chs[k]] = data_q[k + 1];
         if (k < samp_q.size()) begin
            chk({tag, "_sch"}, 32'(samp_q[k][14:12]), 32'(chs[k]));
            chk({tag, "_sdat"}, 32'(samp_q[k][11:0]), 32'(data_q[k + 1]));
         end
      end
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk_rd_all(tag);
   endtask

   initial begin
      int c0;
      for (int c = 0; c < 8; c++) model_res[c] = 12'd0;
      #3 reset = 1'b0;
      repeat (3) step();
      chk_zero("reset");
      reset = 1'b1;
      step();

      // Directed single shot: ch0, ch2 with known engine data.
      eng_lat = 3;
      fixed_q.push_back(12'h111); fixed_q.push_back(12'h222); fixed_q.push_back(12'h333);
      run_scan(8'b0000_0101, "shot05");
      chk("shot05_r0", 32'(model_res[0]), 32'h222);
      chk("shot05_r2", 32'(model_res[2]), 32'h333);

      // Random masks and latencies; results of unmasked channels must persist.
      for (int t = 0; t < 6; t++) begin
         eng_lat = $urandom_range(1, 8);
         run_scan(8'($urandom_range(1, 255)), "rand");
      end
      eng_lat = 2;
      run_scan(8'h80, "single_ch7");
      run_scan(8'hFF, "all_ch");

      // Empty mask: start must be ignored.
      clear_logs();
      i_ch_mask = 8'h00; i_start = 1'b1; step(); i_start = 1'b0;
      repeat (20) step();
      chk("mask0_req", 32'(conf_q.size()), 32'd0);
      chk("mask0_busy", 32'(o_busy), 32'd0);
      chk("mask0_done", 32'(done_cnt), 32'd0);

      // Continuous mode: a scan every 100 cycles, no overrun.
      clear_logs();
      eng_lat = 20; i_ch_mask = 8'h01; i_period = 16'd100;
      i_enable = 1'b1; c0 = cyc;
      repeat (1000) step();
      i_enable = 1'b0;
      for (int k = 0; k < 300 && o_busy === 1'b1; k++) step();
      repeat (3) step();
      chk("cont_nstart", 32'(start_times.size()), 32'd10);
      if (start_times.size() > 0) chk("cont_first", 32'(start_times[0] - c0), 32'd100);
      for (int k = 1; k < start_times.size(); k++)
         chk("cont_interval", 32'(start_times[k] - start_times[k - 1]), 32'd100);
      chk("cont_done", 32'(done_cnt), 32'd10);
      chk("cont_ovr", 32'(o_overrun), 32'd0);

      // Overrun: period 10 with a slow engine; flag_clr alone clears, set beats clear.
      clear_logs();
      eng_lat = 50; i_period = 16'd10;
      i_enable = 1'b1;
      repeat (19) step();
      chk("ovr_before", 32'(o_overrun), 32'd0);
      step();
      chk("ovr_set", 32'(o_overrun), 32'd1);
      repeat (4) step();
      i_flag_clr = 1'b1; step(); i_flag_clr = 1'b0;
      chk("ovr_clr", 32'(o_overrun), 32'd0);
      repeat (4) step();
      i_flag_clr = 1'b1; step(); i_flag_clr = 1'b0;
      chk("ovr_set_wins", 32'(o_overrun), 32'd1);
      i_enable = 1'b0;
      for (int k = 0; k < 400 && o_busy === 1'b1; k++) step();
      chk("ovr_scan_end", 32'(done_cnt), 32'd1);
      i_flag_clr = 1'b1; step(); i_flag_clr = 1'b0;
      chk("ovr_final_clr", 32'(o_overrun), 32'd0);
      i_period = 16'd0;
      for (int c = 0; c < 8; c++) if (c == 0 && data_q.size() > 1) model_res[0] = data_q[1];
      chk_rd_all("ovr");

      // Timeout: engine acks but never completes.
      repeat (10) step();
      clear_logs();
      eng_no_done = 1'b1;
      i_ch_mask = 8'h10; i_start = 1'b1; step(); i_start = 1'b0;
      for (int k = 0; k < 20 && i_conv_ack !== 1'b1; k++) step();
      chk("to_ack_seen", 32'(i_conv_ack), 32'd1);
      repeat (63) step();
      chk("to_early", 32'(o_timeout_err), 32'd0);
      chk("to_busy_early", 32'(o_busy), 32'd1);
      step();
      chk("to_flag", 32'(o_timeout_err), 32'd1);
      chk("to_idle", 32'({o_busy, o_conv_req}), 32'd0);
      repeat (5) step();
      chk("to_no_done", 32'(done_cnt), 32'd0);
      chk("to_nreq", 32'(conf_q.size()), 32'd1);
      i_flag_clr = 1'b1; step(); i_flag_clr = 1'b0;
      chk("to_clr", 32'(o_timeout_err), 32'd0);
      eng_no_done = 1'b0;

      // Reset during WAIT_DONE, then a fresh scan must prime first.
      eng_lat = 30;
      i_ch_mask = 8'h81; i_start = 1'b1; step(); i_start = 1'b0;
      for (int k = 0; k < 20 && i_conv_ack !== 1'b1; k++) step();
      repeat (5) step();
      #3 reset = 1'b0;
      #1;
      for (int c = 0; c < 8; c++) model_res[c] = 12'd0;
      chk_zero("midrst");
      clear_logs();
      repeat (3) step();
      reset = 1'b1;
      for (int k = 0; k < 60 && eng_busy; k++) step();
      repeat (3) step();
      chk("midrst_nosamp", 32'(samp_q.size()), 32'd0);
      chk("midrst_nodone", 32'(done_cnt), 32'd0);
      chk("midrst_busy", 32'(o_busy), 32'd0);
      eng_lat = 3;
      run_scan(8'h81, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
